adpll_cfg_bank: RTL and testbench
=================================

# adpll_cfg_bank

Parametrised configuration bank for the ADPLL core. It is the successor to the edge-clocked parameter latches. All six loop parameters (ndiv, alpha, beta, dco_offset, dco_thresh, kdco) are written synchronously into a shadow bank, then committed atomically into an active bank. The PLL core is held in reset for a programmable window around each commit. The block sits between the chip pins and the ADPLL core, and adds readback and error reporting.

## Interface
Parameters:
- DW, 5, width of pgm_value and of the alpha/beta/dco_offset/dco_thresh/kdco fields
- NDW, 4, width of the ndiv field (NDW <= DW); it takes pgm_value[NDW-1:0]
- HOLD_CYC, 4, number of cycles pll_hold stays asserted per commit (>= 1)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear, level-sensitive
- program  in  1  write strobe; acts on its rising edge
- param_sel  in  3  target of a write: 0 ndiv, 1 alpha, 2 beta, 3 dco_offset, 4 dco_thresh, 5 kdco, 6-7 invalid
- pgm_value  in  DW  write data
- commit  in  1  commit strobe; acts on its rising edge
- rd_src  in  1  readback source: 0 shadow, 1 active
- rd_data  out  DW  readback of the field chosen by param_sel/rd_src, zero-extended
- ndiv  out  NDW  active ndiv
- alpha, beta, dco_offset, dco_thresh, kdco  out  DW each  active fields
- pll_hold  out  1  holds the ADPLL core in reset
- cfg_valid  out  1  at least one commit has completed since the last rst/clr
- err  out  1  sticky error flag

## Operation
- Edge detection:
  - program_q and commit_q register the previous sample of each strobe.
  - An event is strobe=1 with its _q=0, sampled at a clk edge.
  - Both _q registers reset to 1, so a strobe already high at reset release fires no event.
- Write: on a program event with param_sel 0-5, shadow[param_sel] <= pgm_value (ndiv gets the low NDW bits). With param_sel 6 or 7 there is no write and err <= 1.
- Writes are accepted in every state; a write during HOLD affects only the next commit.
- FSM states:
  - IDLE -> HOLD on a commit event when shadow ndiv != 0. On that edge: active <= shadow, pll_hold <= 1, cnt <= HOLD_CYC-1.
  - In IDLE, a commit event with shadow ndiv == 0 is rejected: err <= 1, no state or active change.
  - HOLD: cnt decrements each cycle. When cnt == 0: state <= IDLE, pll_hold <= 0, cfg_valid <= 1.
  - HOLD: a commit event is ignored and sets err <= 1.
- clr=1 (priority over any program/commit in the same cycle):
  - shadow and active are zeroed, cfg_valid <= 0, err <= 0.
  - state <= IDLE and pll_hold <= 0, aborting any HOLD.
  - The edge-detect registers still update.
- rd_data is combinational:
  - param_sel 0-5: the selected field from the bank chosen by rd_src.
  - param_sel 6-7: 0.

## Timing
- Reset values: every shadow/active field 0, state IDLE, pll_hold 0, cfg_valid 0, err 0, rd_data 0, program_q = commit_q = 1.
- A program event at edge n: the shadow field and its shadow readback update after edge n (1-cycle latency).
- A commit event at edge n: active outputs and pll_hold=1 appear after edge n.
- pll_hold stays high for exactly HOLD_CYC cycles and falls after edge n+HOLD_CYC.
- cfg_valid rises at the same edge pll_hold falls.
- A second commit is accepted no earlier than edge n+HOLD_CYC+1.
- A strobe held high produces exactly one event. Re-arming requires at least one low sample.
- A simultaneous program and commit event at edge n: the commit copies the shadow as it was before edge n; the write lands in the shadow only.
- rst asserted mid-HOLD: all outputs go to reset values immediately (asynchronously).

## Test plan
All scenarios use DW=5, NDW=4, HOLD_CYC=4.
- Write then commit:
  - Stimulus: write ndiv=9, alpha=5'h11, kdco=5'h1F, then commit.
  - Required: active outputs update on the commit edge; pll_hold high for exactly 4 cycles; cfg_valid=1 afterwards; readback rd_src=1, param_sel=1 gives 5'h11.
- Shadow isolation:
  - Stimulus: after the first scenario, write alpha=3 without committing.
  - Required: rd_src=0 reads 3; rd_src=1 and the alpha port still read 5'h11.
- Error paths:
  - Stimulus: a write with param_sel=6, then clr, then a commit with ndiv=0 in the shadow, then a commit during HOLD.
  - Required: err=1 and no data change in each case; clr returns err to 0.
- Strobe held high:
  - Stimulus: program held high for 10 cycles while pgm_value changes every cycle.
  - Required: only the first value is stored.
- clr mid-HOLD:
  - Stimulus: clr asserted in the 2nd hold cycle.
  - Required: after the next edge, pll_hold=0, all fields 0, cfg_valid=0.
- Async reset:
  - Stimulus: rst pulsed mid-HOLD between clk edges, with program held high across rst release.
  - Required: outputs zero immediately; no write event after release.

Source files
------------

// File: rtl/adpll_cfg_bank.sv
// ADPLL loop-parameter bank: edge-triggered writes into a shadow bank, atomic
// commit into the active bank, with a timed core hold, readback and sticky error.
module adpll_cfg_bank #(
    parameter int unsigned DW       = 5,
    parameter int unsigned NDW      = 4,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            program_i,
    input  logic [2:0]      param_sel,
    input  logic [DW-1:0]   pgm_value,
    input  logic            commit,
    input  logic            rd_src,
    output logic [DW-1:0]   rd_data,
    output logic [NDW-1:0]  ndiv,
    output logic [DW-1:0]   alpha,
    output logic [DW-1:0]   beta,
    output logic [DW-1:0]   dco_offset,
    output logic [DW-1:0]   dco_thresh,
    output logic [DW-1:0]   kdco,
    output logic            pll_hold,
    output logic            cfg_valid,
    output logic            err
);

    localparam int unsigned NFIELD = 6;
    localparam int unsigned CNT_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [DW-1:0]    NDIV_MASK = DW'((64'd1 << NDW) - 64'd1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               program_q;
    logic               commit_q;
    logic               prog_ev;
    logic               commit_ev;
    logic               sel_valid;
    logic [DW-1:0]      shadow_q [NFIELD];
    logic [DW-1:0]      shadow_d [NFIELD];
    logic [DW-1:0]      active_q [NFIELD];

    assign prog_ev   = program_i & ~program_q;
    assign commit_ev = commit & ~commit_q;
    assign sel_valid = (param_sel < 3'd6);

    // Strobe history resets high so a strobe already asserted at release is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            program_q <= 1'b1;
            commit_q  <= 1'b1;
        end else begin
            program_q <= program_i;
            commit_q  <= commit;
        end
    end

    // Shadow next-state: clr wins, otherwise a program event writes the selected field.
    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            for (int i = 0; i < NFIELD; i++) begin
                shadow_d[i] = '0;
            end
        end else if (prog_ev) begin
            for (int i = 0; i < NFIELD; i++) begin
                if (param_sel == 3'(i)) begin
                    shadow_d[i] = (i == 0) ? (pgm_value & NDIV_MASK) : pgm_value;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NFIELD; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Commit/hold sequencer; active bank copies the pre-edge shadow on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pll_hold  <= 1'b0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NFIELD; i++) begin
                active_q[i] <= '0;
            end
        end else if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pll_hold  <= 1'b0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NFIELD; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            if (prog_ev && !sel_valid) begin
                err <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (commit_ev) begin
                        if (shadow_q[0] != '0) begin
                            active_q <= shadow_q;
                            pll_hold <= 1'b1;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= S_HOLD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (commit_ev) begin
                        err <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q   <= S_IDLE;
                        pll_hold  <= 1'b0;
                        cfg_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    pll_hold <= 1'b0;
                end
            endcase
        end
    end

    assign ndiv       = active_q[0][NDW-1:0];
    assign alpha      = active_q[1];
    assign beta       = active_q[2];
    assign dco_offset = active_q[3];
    assign dco_thresh = active_q[4];
    assign kdco       = active_q[5];

    // Readback mux; unused selects read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NFIELD; i++) begin
            if (param_sel == 3'(i)) begin
                rd_data = rd_src ? active_q[i] : shadow_q[i];
            end
        end
    end

endmodule

// File: tb/tb_adpll_cfg_bank.sv
// Directed and randomized bench for adpll_cfg_bank against a cycle-level
// behavioural model of the shadow/active banks and commit hold window.
module tb_adpll_cfg_bank;

    localparam int DW   = 5;
    localparam int NDW  = 4;
    localparam int HOLD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           program_i;
    logic [2:0]     param_sel;
    logic [DW-1:0]  pgm_value;
    logic           commit;
    logic           rd_src;
    logic [DW-1:0]  rd_data;
    logic [NDW-1:0] ndiv;
    logic [DW-1:0]  alpha, beta, dco_offset, dco_thresh, kdco;
    logic           pll_hold, cfg_valid, err;

    adpll_cfg_bank #(.DW(DW), .NDW(NDW), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst), .clr(clr), .program_i(program_i),
        .param_sel(param_sel), .pgm_value(pgm_value), .commit(commit),
        .rd_src(rd_src), .rd_data(rd_data), .ndiv(ndiv), .alpha(alpha),
        .beta(beta), .dco_offset(dco_offset), .dco_thresh(dco_thresh),
        .kdco(kdco), .pll_hold(pll_hold), .cfg_valid(cfg_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state: banks as plain arrays, hold as cycles remaining.
    logic [DW-1:0] m_sh  [6];
    logic [DW-1:0] m_act [6];
    int            m_hold_left;
    logic          m_valid, m_err, m_pprev, m_cprev;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_hold_left = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_pprev = 1'b1;
        m_cprev = 1'b1;
    endtask

    function automatic logic [DW-1:0] exp_rd();
        int idx;
        idx = int'(param_sel);
        if (idx > 5) return '0;
        return rd_src ? m_act[idx] : m_sh[idx];
    endfunction

    task automatic check_all();
        chk("rd_data",    32'(rd_data),    32'(exp_rd()));
        chk("ndiv",       32'(ndiv),       32'(m_act[0]));
        chk("alpha",      32'(alpha),      32'(m_act[1]));
        chk("beta",       32'(beta),       32'(m_act[2]));
        chk("dco_offset", 32'(dco_offset), 32'(m_act[3]));
        chk("dco_thresh", 32'(dco_thresh), 32'(m_act[4]));
        chk("kdco",       32'(kdco),       32'(m_act[5]));
        chk("pll_hold",   32'(pll_hold),   32'(m_hold_left != 0));
        chk("cfg_valid",  32'(cfg_valid),  32'(m_valid));
        chk("err",        32'(err),        32'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then compare.
    task automatic step(input logic p, input logic [2:0] s, input logic [DW-1:0] v,
                        input logic c, input logic cl, input logic rs);
        logic pe, ce;
        int   idx;
        program_i = p; param_sel = s; pgm_value = v; commit = c; clr = cl; rd_src = rs;
        pe = p && !m_pprev;
        ce = c && !m_cprev;
        m_pprev = p;
        m_cprev = c;
        idx = int'(s);
        if (cl) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            m_hold_left = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            if (m_hold_left > 0) begin
                if (ce) m_err = 1'b1;
                m_hold_left--;
                if (m_hold_left == 0) m_valid = 1'b1;
            end else if (ce) begin
                if (m_sh[0] == '0) m_err = 1'b1;
                else begin
                    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
                    m_hold_left = HOLD;
                end
            end
            if (pe) begin
                if (idx < 6) m_sh[idx] = (idx == 0) ? DW'(v % (1 << NDW)) : v;
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [2:0] s, input logic [DW-1:0] v);
        step(1'b1, s, v, 1'b0, 1'b0, 1'b0);
        step(1'b0, s, v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; program_i = 1'b0; param_sel = '0;
        pgm_value = '0; commit = 1'b0; rd_src = 1'b0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;
        idle(2);

        // Write then commit
        wr(3'd0, 5'd9);
        wr(3'd1, 5'h11);
        wr(3'd5, 5'h1F);
        chk("alpha_pre_commit", 32'(alpha), 32'd0);
        step(1'b0, 3'd1, '0, 1'b1, 1'b0, 1'b1);
        chk("commit_alpha", 32'(alpha), 32'h11);
        chk("commit_ndiv", 32'(ndiv), 32'd9);
        chk("commit_kdco", 32'(kdco), 32'h1F);
        chk("commit_rd_active", 32'(rd_data), 32'h11);
        chk("hold_c0", 32'(pll_hold), 32'd1);
        for (int i = 1; i <= HOLD; i++) begin
            step(1'b0, 3'd1, '0, 1'b0, 1'b0, 1'b1);
            chk("hold_window", 32'(pll_hold), 32'(i < HOLD));
        end
        chk("valid_after_hold", 32'(cfg_valid), 32'd1);

        // Shadow isolation
        wr(3'd1, 5'd3);
        step(1'b0, 3'd1, '0, 1'b0, 1'b0, 1'b0);
        chk("shadow_alpha", 32'(rd_data), 32'd3);
        step(1'b0, 3'd1, '0, 1'b0, 1'b0, 1'b1);
        chk("active_alpha_rd", 32'(rd_data), 32'h11);
        chk("active_alpha_port", 32'(alpha), 32'h11);

        // Error paths
        wr(3'd6, 5'h1F);
        chk("err_bad_sel", 32'(err), 32'd1);
        step(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_valid", 32'(cfg_valid), 32'd0);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
        chk("err_ndiv0", 32'(err), 32'd1);
        chk("ndiv0_no_hold", 32'(pll_hold), 32'd0);
        step(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b0);
        wr(3'd0, 5'd5);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
        wr(3'd0, 5'd7);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
        chk("err_commit_in_hold", 32'(err), 32'd1);
        chk("hold_commit_ignored", 32'(ndiv), 32'd5);
        idle(HOLD + 1);

        // Strobe held high
        step(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 3'd2, DW'(10 + i), 1'b0, 1'b0, 1'b0);
        chk("held_strobe", 32'(rd_data), 32'd10);
        step(1'b0, 3'd2, '0, 1'b0, 1'b0, 1'b0);

        // Simultaneous program and commit
        wr(3'd0, 5'd3);
        step(1'b1, 3'd0, 5'h0C, 1'b1, 1'b0, 1'b0);
        chk("simul_active_ndiv", 32'(ndiv), 32'd3);
        chk("simul_shadow_ndiv", 32'(rd_data), 32'h0C);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0);
        idle(HOLD + 1);

        // clr mid-HOLD
        step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, '0, 1'b0, 1'b1, 1'b1);
        chk("clr_hold", 32'(pll_hold), 32'd0);
        chk("clr_ndiv", 32'(ndiv), 32'd0);
        chk("clr_valid_mid", 32'(cfg_valid), 32'd0);

        // Async reset mid-HOLD with program held across release
        wr(3'd0, 5'd7);
        step(1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1; program_i = 1'b1; param_sel = 3'd1; pgm_value = 5'h15; rd_src = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_hold_async", 32'(pll_hold), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 5'h15, 1'b0, 1'b0, 1'b0);
        chk("rst_no_write", 32'(rd_data), 32'd0);
        step(1'b0, 3'd1, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), DW'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
